// File: rtl/word_uart_bridge.sv
// Word-to-byte UART bridge: an ingress word FIFO feeds a byte serializer on TX,
// and RX bytes are assembled into words. Optional macro WORD_UART_BRIDGE_HEX_EN sends ASCII hex + CR LF.
module word_uart_bridge #(
    parameter int W       = 128,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] word_data_i,
    input  logic         word_valid_i,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [W-1:0] word_data_o,
    output logic         word_valid_o,
    output logic         ovf_o,
    output logic [7:0]   drop_cnt_o
);

    localparam int NB  = W / 8;
    localparam int AW  = $clog2(DEPTH);
`ifdef WORD_UART_BRIDGE_HEX_EN
    localparam int NSTEP = W / 4 + 2;
    localparam int SH    = 4;
`else
    localparam int NSTEP = NB;
    localparam int SH    = 8;
`endif
    localparam int CW  = $clog2(NSTEP + 1);
    localparam int RCW = $clog2(NB + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} tx_state_e;

    logic [W-1:0]   mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic           fifo_empty, fifo_full, push, pop, drop;
    logic           ovf_q, ovf_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;
    tx_state_e      state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [CW-1:0]  step_q, step_d;
    logic           rx_ready_q, rx_ready_d, rx_acc;
    logic [W-1:0]   rx_shift_q, rx_shift_d, rx_next;
    logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
    logic [TW-1:0]  idle_q, idle_d;
    logic [W-1:0]   word_data_q, word_data_d;
    logic           word_valid_q, word_valid_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // LOAD is only reached with a non-empty FIFO, so its pop frees a slot for a same-cycle push.
    assign pop  = (state_q == LOAD);
    assign push = word_valid_i && (!fifo_full || pop);
    assign drop = word_valid_i && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= word_data_i;
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        ovf_d      = drop;
        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

`ifdef WORD_UART_BRIDGE_HEX_EN
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        step_d  = step_q;
        case (state_q)
            IDLE: if (!fifo_empty) state_d = LOAD;
            LOAD: begin
                shift_d = mem_q[rd_ptr_q[AW-1:0]];
                step_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    shift_d = shift_q << SH;
                    if (step_q == CW'(NSTEP - 1)) begin
                        step_d  = '0;
                        state_d = IDLE;
                    end else begin
                        step_d = step_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        if (state_q == SEND) begin
`ifdef WORD_UART_BRIDGE_HEX_EN
            if (step_q < CW'(W / 4))       tx_data = hex_char(shift_q[W-1 -: 4]);
            else if (step_q == CW'(W / 4)) tx_data = 8'h0D;
            else                           tx_data = 8'h0A;
`else
            tx_data = shift_q[W-1 -: 8];
`endif
        end
    end
    assign tx_valid = (state_q == SEND);

    assign rx_acc  = rx_valid && rx_ready_q;
    assign rx_next = {rx_shift_q[W-9:0], rx_data};

    always_comb begin
        rx_ready_d   = 1'b1;
        rx_shift_d   = rx_shift_q;
        rx_cnt_d     = rx_cnt_q;
        idle_d       = idle_q;
        word_data_d  = word_data_q;
        word_valid_d = 1'b0;
        if (rx_acc) begin
            rx_shift_d = rx_next;
            idle_d     = '0;
            if (rx_cnt_q == RCW'(NB - 1)) begin
                word_data_d  = rx_next;
                word_valid_d = 1'b1;
                rx_cnt_d     = '0;
            end else begin
                rx_cnt_d = rx_cnt_q + RCW'(1);
            end
        end else if (rx_cnt_q != '0) begin
            // A stalled partial word is dropped; the stale shift contents get overwritten later.
            if (idle_q == TW'(TIMEOUT - 1)) begin
                rx_cnt_d = '0;
                idle_d   = '0;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 1'b0;
            drop_cnt_q   <= '0;
            state_q      <= IDLE;
            shift_q      <= '0;
            step_q       <= '0;
            rx_ready_q   <= 1'b0;
            rx_shift_q   <= '0;
            rx_cnt_q     <= '0;
            idle_q       <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
            drop_cnt_q   <= drop_cnt_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            step_q       <= step_d;
            rx_ready_q   <= rx_ready_d;
            rx_shift_q   <= rx_shift_d;
            rx_cnt_q     <= rx_cnt_d;
            idle_q       <= idle_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign word_data_o  = word_data_q;
    assign word_valid_o = word_valid_q;
    assign ovf_o        = ovf_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_word_uart_bridge.sv
// Directed bench for word_uart_bridge (W=32, DEPTH=4, TIMEOUT=10); follows WORD_UART_BRIDGE_HEX_EN
// when defined so the TX expectations match the build.
module tb_word_uart_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] word_data_i;
  logic        word_valid_i;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] word_data_o;
  logic        word_valid_o;
  logic        ovf_o;
  logic [7:0]  drop_cnt_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  word_uart_bridge #(.W(32), .DEPTH(4), .TIMEOUT(10)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .word_data_i  (word_data_i),
    .word_valid_i (word_valid_i),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .word_data_o  (word_data_o),
    .word_valid_o (word_valid_o),
    .ovf_o        (ovf_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic push_word(input logic [31:0] w);
    word_valid_i = 1'b1;
    word_data_i  = w;
    @(negedge clk);
    word_valid_i = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    int guard = 0;
    while (tx_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 32'(tx_valid), 32'd1);
  endtask

  task automatic expect_tx(input logic [31:0] w, input bit stall, input string tag);
    logic [7:0] exp_q[$];
    int k = 0;
    bit adv;
`ifdef WORD_UART_BRIDGE_HEX_EN
    for (int i = 0; i < 8; i++) begin
      logic [3:0] nib;
      nib = w[31-4*i -: 4];
      exp_q.push_back((nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h41 + 8'(nib) - 8'd10);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(w[31-8*i -: 8]);
`endif
    wait_tx({tag, "_start"});
    foreach (exp_q[i]) begin
      do begin
        adv = !stall || (k % 3 == 0);
        tx_ready = adv;
        check($sformatf("%s_valid%0d", tag, i), 32'(tx_valid), 32'd1);
        check($sformatf("%s_byte%0d", tag, i), 32'(tx_data), 32'(exp_q[i]));
        @(negedge clk);
        k++;
      end while (!adv);
    end
    check({tag, "_end"}, 32'(tx_valid), 32'd0);
  endtask

  task automatic rx_word(input logic [31:0] w, input string tag);
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = w[31-8*i -: 8];
      @(negedge clk);
      if (i < 3) check($sformatf("%s_nopulse%0d", tag, i), 32'(word_valid_o), 32'd0);
    end
    rx_valid = 1'b0;
    check({tag, "_pulse"}, 32'(word_valid_o), 32'd1);
    check({tag, "_data"}, word_data_o, w);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(word_valid_o), 32'd0);
    check({tag, "_hold"}, word_data_o, w);
  endtask

  initial begin
    int ovf_seen;
    int tx_seen;
    reset_n      = 1'b0;
    word_valid_i = 1'b0;
    word_data_i  = '0;
    tx_ready     = 1'b0;
    rx_data      = '0;
    rx_valid     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_word_valid", 32'(word_valid_o), 32'd0);
    check("rst_word_data", word_data_o, 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rx_ready_after_rst", 32'(rx_ready), 32'd1);

    // Single word, UART always ready.
    tx_ready = 1'b1;
    push_word(32'hA1B2C3D4);
    expect_tx(32'hA1B2C3D4, 1'b0, "tx_basic");

    // Stall pattern 1,0,0,1,...
    push_word(32'h0F1E2D3C);
    expect_tx(32'h0F1E2D3C, 1'b1, "tx_stall");

    // Overflow: the TX engine holds one word first, so the burst lands in the FIFO alone.
    tx_ready = 1'b0;
    push_word(32'h99887766);
    wait_tx("ovf_hold");
    ovf_seen = 0;
    for (int i = 0; i < 6; i++) begin
      ovf_seen += int'(ovf_o);
      word_valid_i = 1'b1;
      word_data_i  = 32'h10203040 + 32'(i);
      @(negedge clk);
    end
    word_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ovf_seen += int'(ovf_o);
      @(negedge clk);
    end
    check("ovf_pulses", 32'(ovf_seen), 32'd2);
    check("ovf_drop_cnt", 32'(drop_cnt_o), 32'd2);
    tx_ready = 1'b1;
    expect_tx(32'h99887766, 1'b0, "drain_hold");
    // FSM is now IDLE; next cycle it is in LOAD and pops while the FIFO is full.
    @(negedge clk);
    push_word(32'h5A5A5A5A);
    check("full_pushpop_ovf", 32'(ovf_o), 32'd0);
    check("full_pushpop_cnt", 32'(drop_cnt_o), 32'd2);
    for (int i = 0; i < 4; i++) expect_tx(32'h10203040 + 32'(i), 1'b0, $sformatf("drain%0d", i));
    expect_tx(32'h5A5A5A5A, 1'b0, "drain_pushpop");
    tx_seen = 0;
    repeat (4) begin
      tx_seen += int'(tx_valid);
      @(negedge clk);
    end
    check("drain_no_extra", 32'(tx_seen), 32'd0);

    // TX and RX traffic together.
    push_word(32'hC0FFEE11);
    fork
      expect_tx(32'hC0FFEE11, 1'b0, "tx_concurrent");
      rx_word(32'h12345678, "rx_basic");
    join
    repeat (3) @(negedge clk);
    check("rx_hold_late", word_data_o, 32'h12345678);

    // Partial word then exactly TIMEOUT idle cycles: discarded.
    rx_valid = 1'b1; rx_data = 8'hAA; @(negedge clk);
    rx_data = 8'hBB; @(negedge clk);
    rx_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("timeout_nopulse", 32'(word_valid_o), 32'd0);
    rx_word(32'h11223344, "rx_timeout");

    // One cycle short of TIMEOUT: partial word survives.
    rx_valid = 1'b1; rx_data = 8'h55; @(negedge clk);
    rx_data = 8'h66; @(negedge clk);
    rx_data = 8'h77; @(negedge clk);
    rx_valid = 1'b0;
    repeat (9) @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h88; @(negedge clk);
    rx_valid = 1'b0;
    check("idle9_pulse", 32'(word_valid_o), 32'd1);
    check("idle9_data", word_data_o, 32'h55667788);

    // Reset in the middle of a TX word and an RX word.
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'hEE; @(negedge clk);
    rx_data = 8'hFF; @(negedge clk);
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    push_word(32'hDEADBEEF);
    wait_tx("mid_start");
    @(negedge clk);
    check("mid_byte2_valid", 32'(tx_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    check("mid_rst_word_data", word_data_o, 32'd0);
    check("mid_rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rx_ready", 32'(rx_ready), 32'd1);
    tx_seen = 0;
    repeat (8) begin
      tx_seen += int'(tx_valid);
      @(negedge clk);
    end
    check("mid_no_resume", 32'(tx_seen), 32'd0);
    rx_word(32'hCAFEF00D, "rx_after_rst");

    // Drop counter saturation.
    tx_ready = 1'b0;
    push_word(32'h01234567);
    wait_tx("sat_hold");
    for (int i = 0; i < 258; i++) begin
      word_valid_i = 1'b1;
      word_data_i  = 32'(i);
      @(negedge clk);
    end
    check("sat_254", 32'(drop_cnt_o), 32'd254);
    repeat (6) @(negedge clk);
    word_valid_i = 1'b0;
    check("sat_255", 32'(drop_cnt_o), 32'd255);
    check("sat_tx_held", 32'(tx_valid), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
